ex_stage: RTL and testbench

- Registered execute stage directly downstream of instruction decode and register-file read.
- Consumes decoded fields plus readData1/readData2 and computes the ALU result and branch/jump resolution.
- Drives the writeback bundle (regWrite, rd, writeData) downstream through a valid/ready handshake.
- Drives the one-cycle branch_tgt/branch_taken/jump_tgt/jump redirect back to the pc block.

---
 rtl/rv_pkg.sv | 58 +++++
 rtl/ex_alu.sv | 35 +++
 rtl/ex_stage.sv | 198 +++++++++++++++++++
 tb/tb_ex_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 execute-stage definitions: opcodes, ALU operations,
// branch funct3 codes, immediate formats and stage state.
package rv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

    typedef enum logic {ST_EMPTY, ST_FULL} stage_state_t;

    // Sign-extended 32-bit immediate for the requested encoding format.
    function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_t fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = {{20{ins[31]}}, ins[31:20]};
        endcase
        return imm;
    endfunction

    // Map funct3 to an ALU operation; alt selects SUB/SRA variants.
    function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational integer ALU for the execute stage.
module ex_alu
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  alu_op_t         i_op,
    output logic [XLEN-1:0] o_result
);

    logic [4:0] w_shamt;
    assign w_shamt = i_b[4:0];

    // Select the result of the requested operation.
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:   o_result = i_a + i_b;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_SLL:   o_result = i_a << w_shamt;
            ALU_SLT:   o_result = XLEN'($signed(i_a) < $signed(i_b));
            ALU_SLTU:  o_result = XLEN'(i_a < i_b);
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SRL:   o_result = i_a >> w_shamt;
            ALU_SRA:   o_result = $signed(i_a) >>> w_shamt;
            ALU_OR:    o_result = i_a | i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_PASSB: o_result = i_b;
            default:   o_result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Registered execute stage: decode-to-writeback ALU, branch/jump
// resolution and a one-cycle redirect pulse, behind a valid/ready register.
module ex_stage
    import rv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          SQUASH_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     instruction,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] readData1,
    input  logic [XLEN-1:0] readData2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            regWrite,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] writeData,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_tgt,
    output logic            jump,
    output logic [XLEN-1:0] jump_tgt,
    output logic            illegal,
    output logic            misaligned
);

    stage_state_t    r_state, w_state_next;
    logic            r_regwrite, r_branch_taken, r_jump, r_illegal, r_misaligned;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_wdata, r_br_tgt, r_jmp_tgt;

    logic [XLEN-1:0] w_imm_i, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0] w_alu_a, w_alu_b, w_alu_res;
    logic [XLEN-1:0] w_br_tgt, w_jmp_tgt;
    alu_op_t         w_alu_op;
    logic            w_rw, w_ill, w_is_br, w_is_jal, w_is_jalr, w_cond;
    logic            w_take_br, w_take_j, w_mis;
    logic            w_full, w_accept, w_redir_pending, w_squash, w_load;

    assign w_imm_i = XLEN'($signed(imm_gen(instruction, IMM_I)));
    assign w_imm_b = XLEN'($signed(imm_gen(instruction, IMM_B)));
    assign w_imm_u = XLEN'($signed(imm_gen(instruction, IMM_U)));
    assign w_imm_j = XLEN'($signed(imm_gen(instruction, IMM_J)));

    // Control decode: ALU operands/operation, write enable, legality.
    always_comb begin
        w_alu_op  = ALU_ADD;
        w_alu_a   = readData1;
        w_alu_b   = readData2;
        w_rw      = 1'b0;
        w_ill     = 1'b0;
        w_is_br   = 1'b0;
        w_is_jal  = 1'b0;
        w_is_jalr = 1'b0;
        case (opcode)
            OPC_OP: begin
                w_rw     = 1'b1;
                w_alu_op = alu_op_from_f3(funct3, funct7[5]);
                w_ill    = !((funct7 == 7'b0000000) ||
                             (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OPIMM: begin
                w_rw     = 1'b1;
                w_alu_b  = w_imm_i;
                w_alu_op = alu_op_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
            end
            OPC_LUI: begin
                w_rw     = 1'b1;
                w_alu_b  = w_imm_u;
                w_alu_op = ALU_PASSB;
            end
            OPC_AUIPC: begin
                w_rw    = 1'b1;
                w_alu_a = in_pc;
                w_alu_b = w_imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                w_rw      = 1'b1;
                w_alu_a   = in_pc;
                w_alu_b   = XLEN'(32'd4);
                w_is_jal  = (opcode == OPC_JAL);
                w_is_jalr = (opcode == OPC_JALR);
            end
            OPC_BRANCH: begin
                w_is_br = 1'b1;
                w_ill   = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Branch condition evaluation.
    always_comb begin
        w_cond = 1'b0;
        case (funct3)
            F3_BEQ:  w_cond = (readData1 == readData2);
            F3_BNE:  w_cond = (readData1 != readData2);
            F3_BLT:  w_cond = ($signed(readData1) <  $signed(readData2));
            F3_BGE:  w_cond = ($signed(readData1) >= $signed(readData2));
            F3_BLTU: w_cond = (readData1 <  readData2);
            F3_BGEU: w_cond = (readData1 >= readData2);
            default: w_cond = 1'b0;
        endcase
    end

    ex_alu #(.XLEN(XLEN)) u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_op     (w_alu_op),
        .o_result (w_alu_res)
    );

    assign w_br_tgt  = in_pc + w_imm_b;
    assign w_jmp_tgt = w_is_jalr ? ((readData1 + w_imm_i) & ~XLEN'(32'd1))
                                 : (in_pc + w_imm_j);
    assign w_take_br = w_is_br && !w_ill && w_cond;
    assign w_take_j  = (w_is_jal || w_is_jalr) && !w_ill;
    assign w_mis     = (w_take_br && w_br_tgt[1]) || (w_take_j && w_jmp_tgt[1]);

    assign w_full          = (r_state == ST_FULL);
    assign in_ready        = !w_full || out_ready;
    assign w_accept        = in_valid && in_ready;
    assign w_redir_pending = r_branch_taken || r_jump;
    // An accept during the redirect pulse completes the handshake but is not loaded.
    assign w_squash        = SQUASH_EN && w_redir_pending;

    // Occupancy state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_EMPTY;
        else        r_state <= w_state_next;
    end

    // Next occupancy and load decision.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept && !w_squash) begin
                    w_load       = 1'b1;
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_accept && !w_squash) w_load = 1'b1;
                else if (out_ready)        w_state_next = ST_EMPTY;
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // Output bundle register; redirect bits last only the first valid cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regwrite     <= 1'b0;
            r_rd           <= '0;
            r_wdata        <= '0;
            r_br_tgt       <= '0;
            r_jmp_tgt      <= '0;
            r_branch_taken <= 1'b0;
            r_jump         <= 1'b0;
            r_illegal      <= 1'b0;
            r_misaligned   <= 1'b0;
        end else if (w_load) begin
            r_regwrite     <= w_rw && !w_ill && (rd != 5'd0);
            r_rd           <= rd;
            r_wdata        <= w_alu_res;
            r_br_tgt       <= w_br_tgt;
            r_jmp_tgt      <= w_jmp_tgt;
            r_branch_taken <= w_take_br;
            r_jump         <= w_take_j;
            r_illegal      <= w_ill;
            r_misaligned   <= w_mis;
        end else begin
            r_branch_taken <= 1'b0;
            r_jump         <= 1'b0;
        end
    end

    assign out_valid    = w_full;
    assign regWrite     = r_regwrite && w_full;
    assign rd_out       = r_rd;
    assign writeData    = r_wdata;
    assign branch_taken = r_branch_taken;
    assign branch_tgt   = r_br_tgt;
    assign jump         = r_jump;
    assign jump_tgt     = r_jmp_tgt;
    assign illegal      = r_illegal;
    assign misaligned   = r_misaligned;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_ex_stage;

    localparam bit SQ = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, instruction, readData1, readData2;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rd_out;
    logic [2:0]  funct3;
    logic        regWrite, branch_taken, jump, illegal, misaligned;
    logic [31:0] writeData, branch_tgt, jump_tgt;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32), .SQUASH_EN(SQ)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .instruction(instruction), .opcode(opcode), .rd(rd),
        .funct3(funct3), .funct7(funct7),
        .readData1(readData1), .readData2(readData2),
        .out_valid(out_valid), .out_ready(out_ready),
        .regWrite(regWrite), .rd_out(rd_out), .writeData(writeData),
        .branch_taken(branch_taken), .branch_tgt(branch_tgt),
        .jump(jump), .jump_tgt(jump_tgt),
        .illegal(illegal), .misaligned(misaligned)
    );

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        bt;
        logic [31:0] btgt;
        logic        j;
        logic [31:0] jtgt;
        logic        ill;
        logic        mis;
        logic        cmp_wd;
        logic        cmp_bt;
        logic        cmp_jt;
    } exp_t;

    exp_t        m;
    logic        m_valid;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of one instruction, from the ISA rules.
    function automatic exp_t ref_exec(input logic [31:0] pc, input logic [31:0] ins,
                                      input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int          immI, immB, immJ;
        logic [31:0] immU, opb;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        is_op, alt;
        e    = '0;
        e.rd = ins[11:7];
        f3   = ins[14:12];
        f7   = ins[31:25];
        immI = $signed(ins[31:20]);
        immB = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        immJ = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        immU = ins & 32'hFFFF_F000;
        case (ins[6:0])
            7'h33, 7'h13: begin
                is_op = (ins[6:0] == 7'h33);
                opb   = is_op ? b : 32'(immI);
                alt   = is_op ? (f7 == 7'h20) : ins[30];
                if (is_op && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) e.ill = 1'b1;
                case (f3)
                    3'd0: e.wd = (is_op && alt) ? a - opb : a + opb;
                    3'd1: e.wd = a << opb[4:0];
                    3'd2: e.wd = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
                    3'd3: e.wd = (a < opb) ? 32'd1 : 32'd0;
                    3'd4: e.wd = a ^ opb;
                    3'd5: e.wd = alt ? 32'($signed(a) >>> opb[4:0]) : a >> opb[4:0];
                    3'd6: e.wd = a | opb;
                    default: e.wd = a & opb;
                endcase
                e.rw = 1'b1;
            end
            7'h37: begin e.wd = immU;      e.rw = 1'b1; end
            7'h17: begin e.wd = pc + immU; e.rw = 1'b1; end
            7'h6F: begin e.wd = pc + 4; e.rw = 1'b1; e.j = 1'b1; e.jtgt = pc + 32'(immJ); end
            7'h67: begin e.wd = pc + 4; e.rw = 1'b1; e.j = 1'b1; e.jtgt = (a + 32'(immI)) & ~32'h1; end
            7'h63: begin
                e.btgt = pc + 32'(immB);
                case (f3)
                    3'd0: e.bt = (a == b);
                    3'd1: e.bt = (a != b);
                    3'd4: e.bt = ($signed(a) < $signed(b));
                    3'd5: e.bt = ($signed(a) >= $signed(b));
                    3'd6: e.bt = (a < b);
                    3'd7: e.bt = (a >= b);
                    default: e.ill = 1'b1;
                endcase
                e.cmp_bt = !e.ill;
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin e.rw = 1'b0; e.bt = 1'b0; e.j = 1'b0; end
        e.cmp_wd = !e.ill && (ins[6:0] != 7'h63);
        e.cmp_jt = e.j;
        e.mis    = (e.bt && e.btgt[1]) || (e.j && e.jtgt[1]);
        if (e.rd == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    // Advance the model by one rising edge using the inputs the DUT sees.
    task automatic model_step();
        logic pulse, accept;
        if (!reset) begin
            m_valid = 1'b0;
            m       = '0;
            return;
        end
        pulse  = m.bt || m.j;
        accept = in_valid && (!m_valid || out_ready);
        if (accept && !(SQ && pulse)) begin
            m       = ref_exec(in_pc, instruction, readData1, readData2);
            m_valid = 1'b1;
        end else begin
            m.bt = 1'b0;
            m.j  = 1'b0;
            if (m_valid && out_ready) m_valid = 1'b0;
        end
    endtask

    // Compare every DUT output against the model each cycle.
    always @(negedge clk) begin
        #2;
        chk("in_ready",     in_ready,     !m_valid || out_ready);
        chk("out_valid",    out_valid,    m_valid);
        chk("regWrite",     regWrite,     m_valid && m.rw);
        chk("branch_taken", branch_taken, m_valid && m.bt);
        chk("jump",         jump,         m_valid && m.j);
        if (m_valid) begin
            chk("rd_out",     rd_out,     m.rd);
            chk("illegal",    illegal,    m.ill);
            chk("misaligned", misaligned, m.mis);
            if (m.cmp_wd) chk("writeData",  writeData,  m.wd);
            if (m.cmp_bt) chk("branch_tgt", branch_tgt, m.btgt);
            if (m.cmp_jt) chk("jump_tgt",   jump_tgt,   m.jtgt);
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b, input logic ordy);
        in_valid    = v;
        in_pc       = pc;
        instruction = ins;
        opcode      = ins[6:0];
        rd          = ins[11:7];
        funct3      = ins[14:12];
        funct7      = ins[31:25];
        readData1   = a;
        readData2   = b;
        out_ready   = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #3;
    endtask

    localparam logic [31:0] I_ADD  = {7'h00, 5'd2, 5'd1, 3'b000, 5'd5, 7'h33};
    localparam logic [31:0] I_SRA  = {7'h20, 5'd2, 5'd1, 3'b101, 5'd6, 7'h33};
    localparam logic [31:0] I_BEQ  = {1'b1, 6'h3F, 5'd2, 5'd1, 3'b000, 4'b1100, 1'b1, 7'h63};
    localparam logic [31:0] I_JALR = {12'h000, 5'd1, 3'b000, 5'd1, 7'h67};
    localparam logic [31:0] I_BNE  = {1'b0, 6'h00, 5'd2, 5'd1, 3'b001, 4'b1000, 1'b0, 7'h63};
    localparam logic [31:0] I_ADD9 = {7'h00, 5'd2, 5'd1, 3'b000, 5'd9, 7'h33};

    logic [31:0] ins, a, b, saved_tgt;
    int          k;

    initial begin
        m       = '0;
        m_valid = 1'b0;
        reset   = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        repeat (2) @(negedge clk);
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_writeData", writeData, 32'h0);
        chk("rst_in_ready",  in_ready,  1'b1);
        reset = 1'b1;

        // ADD wrap-around, then back-to-back SRA.
        drive(1'b1, 32'h0, I_ADD, 32'hFFFF_FFFF, 32'h2, 1'b1);
        step();
        chk("add_valid", out_valid, 1'b1);
        chk("add_wd",    writeData, 32'h1);
        chk("add_rw",    regWrite,  1'b1);
        chk("add_rd",    rd_out,    5'd5);
        drive(1'b1, 32'h0, I_SRA, 32'h8000_0000, 32'h24, 1'b1);
        step();
        chk("sra_wd", writeData, 32'hF800_0000);

        // Taken BEQ; the instruction offered in the pulse cycle is squashed.
        drive(1'b1, 32'h100, I_BEQ, 32'h7, 32'h7, 1'b1);
        step();
        chk("beq_taken", branch_taken, 1'b1);
        chk("beq_tgt",   branch_tgt,   32'h0F8);
        chk("beq_rw",    regWrite,     1'b0);
        drive(1'b1, 32'h0, I_ADD, 32'h1, 32'h1, 1'b1);
        step();
        chk("squash_valid", out_valid,    1'b0);
        chk("squash_pulse", branch_taken, 1'b0);

        // JALR with a target that has bit1 set.
        drive(1'b1, 32'h40, I_JALR, 32'h1003, 32'h0, 1'b1);
        step();
        chk("jalr_jump", jump,       1'b1);
        chk("jalr_tgt",  jump_tgt,   32'h1002);
        chk("jalr_mis",  misaligned, 1'b1);
        chk("jalr_wd",   writeData,  32'h44);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        step();

        // Taken BNE held under a three-cycle stall, then drained with a new accept.
        drive(1'b1, 32'h200, I_BNE, 32'h1, 32'h2, 1'b1);
        step();
        chk("bne_taken", branch_taken, 1'b1);
        saved_tgt = branch_tgt;
        chk("bne_tgt", saved_tgt, 32'h210);
        drive(1'b1, 32'h0, I_ADD9, 32'h3, 32'h4, 1'b0);
        #1;
        chk("stall_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pulse", branch_taken, 1'b0);
            chk("stall_valid", out_valid,    1'b1);
            chk("stall_tgt",   branch_tgt,   saved_tgt);
            chk("stall_ready", in_ready,     1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("drain_in_ready", in_ready, 1'b1);
        step();
        chk("drain_next_valid", out_valid, 1'b1);
        chk("drain_next_wd",    writeData, 32'h7);
        chk("drain_next_rd",    rd_out,    5'd9);

        // Asynchronous reset in the middle of a stall.
        drive(1'b1, 32'h0, I_ADD, 32'hA, 32'h14, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        chk("pre_rst_valid", out_valid, 1'b1);
        reset   = 1'b0;
        m       = '0;
        m_valid = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_rw",    regWrite,  1'b0);
        chk("arst_wd",    writeData, 32'h0);
        chk("arst_rd",    rd_out,    5'd0);
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("post_rst_ready", in_ready,  1'b1);
        chk("post_rst_valid", out_valid, 1'b0);

        // Randomized traffic checked by the compare process.
        for (int c = 0; c < 3000; c++) begin
            ins = $urandom;
            k   = $urandom_range(0, 9);
            case (k)
                0, 1: begin
                    ins[6:0] = 7'h33;
                    case ($urandom_range(0, 3))
                        0, 1:    ins[31:25] = 7'h00;
                        2:       ins[31:25] = 7'h20;
                        default: ins[31:25] = 7'($urandom);
                    endcase
                end
                2:       ins[6:0] = 7'h13;
                3:       ins[6:0] = 7'h37;
                4:       ins[6:0] = 7'h17;
                5:       ins[6:0] = 7'h6F;
                6:       ins[6:0] = 7'h67;
                7, 8:    ins[6:0] = 7'h63;
                default: ins[6:0] = 7'($urandom);
            endcase
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 40));
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, ins, a, b,
                  $urandom_range(0, 9) < 7);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
